btn_event_ctrl: RTL and testbench

- Sits between the per-button `debounce` instances and the binary-counter logic.
- Turns up to NUM_BTN debounced button levels into a single stream of events: press, long-press and optional auto-repeat.
- Arbitrates round-robin among buttons with simultaneous pending presses.
- Tracks hold time for one active button and buffers events in a small FIFO behind a valid/ready handshake.

---
 rtl/btn_evt_pkg.sv | 14 +
 rtl/evt_fifo.sv | 53 +++++
 rtl/btn_event_ctrl.sv | 162 ++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event codes and hold-FSM state type for the button event controller.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } hold_st_t;

endpackage

// File: rtl/evt_fifo.sv
// Show-ahead FIFO: head entry is presented from storage while not empty.
// A push on full is accepted only together with a pop; dropped pushes are the caller's concern.
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  // Empty head reads as zero so stale storage never leaks onto the outputs.
  assign dout  = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounced button levels -> PRESS/LONG/REPEAT event stream with round-robin arbitration.
// Auto-repeat in the HELD state is built only when BTN_AUTOREPEAT_EN is defined.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int          NUM_BTN       = 4,
  parameter logic [23:0] LONG_CYCLES   = 24'd13_500_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd2_700_000,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_lvl,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic [1:0]                 evt_kind,
  output logic                       overflow
);
  localparam int ID_W = $clog2(NUM_BTN);
  // Shared timer is sized for the longer interval so its width is build-independent.
  localparam logic [23:0] TMR_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 24'd1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 24'd1);
`endif

  logic [NUM_BTN-1:0] btn_q_reg;
  logic [NUM_BTN-1:0] pending_reg;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] grant_vec;
  logic [ID_W-1:0]    last_grant_reg;
  logic [ID_W-1:0]    grant_id;
  logic               grant_found;
  logic               grant_valid;
  hold_st_t           state_reg;
  logic [ID_W-1:0]    act_id_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic               act_lvl;
  logic               hold_wr;
  logic [1:0]         hold_kind;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ID_W+1:0]    push_data;
  logic [ID_W+1:0]    head_data;
  logic               overflow_reg;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    assign rise[gi]      = btn_lvl[gi] & ~btn_q_reg[gi];
    assign grant_vec[gi] = grant_valid && (grant_id == ID_W'(gi));
  end

  // Round-robin: first pending button after the last one granted.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      if (!grant_found && pending_reg[ID_W'((int'(last_grant_reg) + k) % NUM_BTN)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(last_grant_reg) + k) % NUM_BTN);
      end
    end
  end

  assign act_lvl = btn_lvl[act_id_reg];

  // Timer events are suppressed by a same-cycle release.
  always_comb begin
    hold_wr   = 1'b0;
    hold_kind = EVT_LONG;
    if (state_reg == ST_PRESSED && act_lvl && timer_reg == LONG_LAST) hold_wr = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
    if (state_reg == ST_HELD && act_lvl && timer_reg == REPEAT_LAST) begin
      hold_wr   = 1'b1;
      hold_kind = EVT_REPEAT;
    end
`endif
  end

  assign grant_valid = grant_found & ~hold_wr;
  assign push        = hold_wr | grant_valid;
  assign push_data   = hold_wr ? {act_id_reg, hold_kind} : {grant_id, EVT_PRESS};
  assign pop         = ~fifo_empty & evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q_reg      <= '0;
      pending_reg    <= '0;
      last_grant_reg <= ID_W'(NUM_BTN - 1);
      overflow_reg   <= 1'b0;
    end else begin
      btn_q_reg   <= btn_lvl;
      pending_reg <= (pending_reg & ~grant_vec) | rise;
      if (grant_valid) last_grant_reg <= grant_id;
      if (push && fifo_full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      act_id_reg <= '0;
      timer_reg  <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            act_id_reg <= grant_id;
            timer_reg  <= '0;
            state_reg  <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!act_lvl) begin
            state_reg <= ST_IDLE;
          end else if (timer_reg == LONG_LAST) begin
            timer_reg <= '0;
            state_reg <= ST_HELD;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        ST_HELD: begin
          if (!act_lvl) begin
            state_reg <= ST_IDLE;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (timer_reg == REPEAT_LAST) begin
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
`endif
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  evt_fifo #(
    .WIDTH (ID_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head_data),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_id    = head_data[ID_W+1:2];
  assign evt_kind  = head_data[1:0];
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: event-level reference model compared every cycle, plus directed scenarios.
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 4;
  localparam int LONG  = 8;
  localparam int REP   = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_lvl = 4'h0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_kind;
  logic       overflow;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .NUM_BTN       (NB),
    .LONG_CYCLES   (24'd8),
    .REPEAT_CYCLES (24'd4),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_lvl   (btn_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_kind  (evt_kind),
    .overflow  (overflow)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: event queue plus "edges since grant" for the active button.
  logic [3:0] m_q, m_pend;
  int  m_last, m_act, m_age;
  bit  m_hold, m_ovf;
  int  m_fifo[$];
  int  log_code[$];
  int  log_cyc[$];

  function automatic int enc(input int id, input int kind);
    return id * 4 + kind;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_pend = '0; m_last = NB - 1;
    m_hold = 1'b0; m_act = 0; m_age = 0; m_ovf = 1'b0;
    m_fifo.delete();
  endtask

  task automatic model_step(input logic [3:0] b, input logic rdy);
    bit was_hold, ev, pop;
    int ev_code;
    was_hold = m_hold;
    ev = 1'b0;
    ev_code = 0;
    if (m_hold) begin
      if (!b[m_act]) m_hold = 1'b0;
      else begin
        m_age++;
        if (m_age == LONG) begin
          ev = 1'b1; ev_code = enc(m_act, 2);
        end else if (AR && m_age > LONG && (m_age - LONG) % REP == 0) begin
          ev = 1'b1; ev_code = enc(m_act, 3);
        end
      end
    end
    if (!ev) begin
      for (int k = 1; k <= NB; k++) begin
        int i;
        i = (m_last + k) % NB;
        if (!ev && m_pend[i]) begin
          ev = 1'b1; ev_code = enc(i, 1);
          m_pend[i] = 1'b0; m_last = i;
          if (!was_hold) begin m_hold = 1'b1; m_act = i; m_age = 0; end
        end
      end
    end
    m_pend = m_pend | (b & ~m_q);
    m_q = b;
    pop = (m_fifo.size() > 0) && rdy;
    if (pop) void'(m_fifo.pop_front());
    if (ev) begin
      if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
      else m_fifo.push_back(ev_code);
    end
  endtask

  task automatic compare_outputs();
    int exp_v, exp_id, exp_k, exp_all, act_all;
    exp_v  = (m_fifo.size() > 0) ? 1 : 0;
    exp_id = exp_v ? m_fifo[0] / 4 : 0;
    exp_k  = exp_v ? m_fifo[0] % 4 : 0;
    exp_all = exp_v * 32 + exp_id * 8 + exp_k * 2 + int'(m_ovf);
    act_all = int'({evt_valid, evt_id, evt_kind, overflow});
    check("model_outputs{valid,id,kind,ovf}", act_all, exp_all);
  endtask

  task automatic tick();
    if (evt_valid && evt_ready) begin
      log_code.push_back(enc(int'(evt_id), int'(evt_kind)));
      log_cyc.push_back(cyc);
    end
    if (rst) model_reset();
    else model_step(btn_lvl, evt_ready);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_outputs();
  endtask

  task automatic clear_log();
    log_code.delete();
    log_cyc.delete();
  endtask

  task automatic check_log(input string name, input int n, input int codes[8], input int dcyc[8]);
    check({name, "_count"}, log_code.size(), n);
    for (int i = 0; i < n; i++) begin
      check({name, "_code"}, (i < log_code.size()) ? log_code[i] : -1, codes[i]);
      check({name, "_delta"}, (i < log_cyc.size()) ? log_cyc[i] - log_cyc[0] : -1, dcyc[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int codes[8];
    int dcyc[8];

    // Reset state
    model_reset();
    @(negedge clk);
    check("reset_valid", int'(evt_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_kind", int'(evt_kind), 0);
    tick();
    tick();
    rst = 1'b0;

    // Simultaneous press, then a second burst: both start at id 0
    for (int burst = 0; burst < 2; burst++) begin
      clear_log();
      btn_lvl = 4'hF;
      repeat (5) tick();
      btn_lvl = 4'h0;
      repeat (8) tick();
      codes = '{1, 5, 9, 13, 0, 0, 0, 0};
      dcyc  = '{0, 1, 2, 3, 0, 0, 0, 0};
      check_log(burst == 0 ? "burst1" : "burst2", 4, codes, dcyc);
    end

    // Single tap: visible exactly 2 edges after the rise
    clear_log();
    btn_lvl = 4'h1;
    tick();
    check("tap_after_e0_valid", int'(evt_valid), 0);
    tick();
    check("tap_after_e1_valid", int'(evt_valid), 1);
    check("tap_after_e1_id", int'(evt_id), 0);
    check("tap_after_e1_kind", int'(evt_kind), int'(EVT_PRESS));
    tick();
    btn_lvl = 4'h0;
    repeat (15) tick();
    codes = '{1, 0, 0, 0, 0, 0, 0, 0};
    dcyc  = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_log("tap", 1, codes, dcyc);

    // Long hold on button 2 for 20 cycles
    clear_log();
    btn_lvl = 4'h4;
    repeat (20) tick();
    btn_lvl = 4'h0;
    repeat (15) tick();
    codes = '{9, 10, 11, 11, 0, 0, 0, 0};
    dcyc  = '{0, 8, 12, 16, 0, 0, 0, 0};
    check_log("long_hold", AR ? 4 : 2, codes, dcyc);

    // LONG 0 and a rise on 1 compete for the same write slot
    clear_log();
    btn_lvl = 4'h1;
    repeat (8) tick();
    btn_lvl = 4'h3;
    repeat (4) tick();
    btn_lvl = 4'h0;
    repeat (12) tick();
    codes = '{1, 2, 5, 0, 0, 0, 0, 0};
    dcyc  = '{0, 8, 9, 0, 0, 0, 0, 0};
    check_log("collision", 3, codes, dcyc);

    // Backpressure: six presses into a four-entry FIFO
    clear_log();
    evt_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      btn_lvl = 4'h1 << (p % 4);
      repeat (2) tick();
      btn_lvl = 4'h0;
      repeat (2) tick();
    end
    check("bp_head_valid", int'(evt_valid), 1);
    check("bp_head_id", int'(evt_id), 0);
    check("bp_overflow", int'(overflow), 1);
    evt_ready = 1'b1;
    repeat (6) tick();
    codes = '{1, 5, 9, 13, 0, 0, 0, 0};
    dcyc  = '{0, 1, 2, 3, 0, 0, 0, 0};
    check_log("bp_drain", 4, codes, dcyc);
    check("bp_overflow_sticky", int'(overflow), 1);

    // Async reset mid-hold with two events queued
    evt_ready = 1'b0;
    btn_lvl = 4'h1;
    repeat (3) tick();
    btn_lvl = 4'h3;
    repeat (3) tick();
    btn_lvl = 4'h1;
    check("prerst_valid", int'(evt_valid), 1);
    check("prerst_overflow", int'(overflow), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(evt_valid), 0);
    check("async_rst_overflow", int'(overflow), 0);
    model_reset();
    tick();
    rst = 1'b0;
    evt_ready = 1'b1;
    tick();
    check("postrst_e0_valid", int'(evt_valid), 0);
    tick();
    check("postrst_e1_valid", int'(evt_valid), 1);
    check("postrst_e1_id", int'(evt_id), 0);
    check("postrst_e1_kind", int'(evt_kind), int'(EVT_PRESS));
    btn_lvl = 4'h0;
    repeat (10) tick();

    // Randomized stimulus, alternating light and heavy backpressure
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 11) == 0) btn_lvl[b] = ~btn_lvl[b];
      evt_ready = ($urandom_range(0, 99) < (((n / 300) % 2) ? 15 : 85));
      if (n == 2500) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
